// File: rtl/seq_det_ctrl.sv
// Sequencer for a serial Moore sequence detector: accepts a word, clears the detector,
// shifts the word MSB-first and collects a per-bit match map and a saturating match count.
module seq_det_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              CK,
    input  logic              R,
    input  logic [WORD_W-1:0] WORD_IN,
    input  logic              WORD_VALID,
    output logic              WORD_READY,
    input  logic              ABORT,
    output logic              DET_IN,
    output logic              DET_R,
    input  logic              DET_HIT,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  MATCH_CNT,
    output logic [WORD_W-1:0] MATCH_MAP
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  word_sr;
    logic [IDX_W-1:0]   idx;
    logic               active;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign active     = (state == S_CLR) || (state == S_SHIFT) || (state == S_DRAIN);
    // An abort clears the detector in the same cycle the controller falls back to idle.
    assign DET_R      = R || (state == S_CLR) || (ABORT && active);
    assign WORD_READY = (state == S_IDLE) && !R;

    always_ff @(posedge CK) begin
        if (R) begin
            state     <= S_IDLE;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            DET_IN    <= 1'b0;
            MATCH_CNT <= '0;
            MATCH_MAP <= '0;
            idx       <= '0;
        end else if (ABORT && active) begin
            state     <= S_IDLE;
            BUSY      <= 1'b0;
            DET_IN    <= 1'b0;
            MATCH_CNT <= '0;
            MATCH_MAP <= '0;
            idx       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (WORD_VALID) begin
                        word_sr   <= WORD_IN;
                        MATCH_CNT <= '0;
                        MATCH_MAP <= '0;
                        BUSY      <= 1'b1;
                        DET_IN    <= 1'b0;
                        state     <= S_CLR;
                    end
                end
                S_CLR: begin
                    DET_IN  <= word_sr[WORD_W-1];
                    word_sr <= word_sr << 1;
                    idx     <= '0;
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    // The detector output lags its input by one cycle, so the hit seen now
                    // belongs to the previous bit; at k=0 it still reflects the cleared state.
                    if (idx != '0 && DET_HIT) begin
                        MATCH_MAP[idx - 1'b1] <= 1'b1;
                        MATCH_CNT             <= sat_inc(MATCH_CNT);
                    end
                    if (idx == LAST_IDX) begin
                        DET_IN <= 1'b0;
                        state  <= S_DRAIN;
                    end else begin
                        DET_IN  <= word_sr[WORD_W-1];
                        word_sr <= word_sr << 1;
                        idx     <= idx + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (DET_HIT) begin
                        MATCH_MAP[WORD_W-1] <= 1'b1;
                        MATCH_CNT           <= sat_inc(MATCH_CNT);
                    end
                    DET_IN <= 1'b0;
                    BUSY   <= 1'b0;
                    DONE   <= 1'b1;
                    idx    <= '0;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    BUSY   <= 1'b0;
                    DONE   <= 1'b0;
                    DET_IN <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
